// File: rtl/key_event_pkg.sv
// Shared state encoding and helpers for the key event decoder.
package key_event_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE        = 2'd0;
  localparam state_t ST_DEB_PRESS   = 2'd1;
  localparam state_t ST_HELD        = 2'd2;
  localparam state_t ST_DEB_RELEASE = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key: 2-flop synchroniser, debounce FSM and event pulses.
// Optional auto-repeat of key_press while held: define KEY_AUTOREPEAT_EN.
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_sw,
  output logic key_pressed,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  // The cycle that leaves IDLE/HELD already counts as the first stable sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

  logic             sync1_q, sync2_q;
  logic             p_c;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             armed_q, armed_d;
`else
  logic [63:0] unused_repeat_cfg;
  assign unused_repeat_cfg = {32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  assign p_c = ~sync2_q;

  // Debounce FSM and event generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rpt_d     = rpt_q;
    armed_d   = armed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (p_c) begin
          state_d = ST_DEB_PRESS;
          cnt_d   = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (!p_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_HELD;
          pressed_d = 1'b1;
          press_d   = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          rpt_d     = '0;
          armed_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!p_c) begin
          state_d = ST_DEB_RELEASE;
          cnt_d   = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rpt_q == (armed_q ? RPT_NEXT : RPT_FIRST)) begin
          press_d = 1'b1;
          rpt_d   = '0;
          armed_d = 1'b1;
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
`endif
      end
      ST_DEB_RELEASE: begin
        if (p_c) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          pressed_d = 1'b0;
          release_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          rpt_d     = '0;
          armed_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchronisers preset to "released" so reset never produces a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q     <= '0;
      armed_q   <= 1'b0;
`endif
    end else begin
      sync1_q   <= key_sw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
      armed_q   <= armed_d;
`endif
    end
  end

  assign key_pressed = pressed_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_event_decoder.sv
// Debounced level and press/release pulses for W active-low push keys.
// Optional auto-repeat of key_press while held: define KEY_AUTOREPEAT_EN.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned W             = 4,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] key_sw,
  output logic [W-1:0] key_pressed,
  output logic [W-1:0] key_press,
  output logic [W-1:0] key_release
);

  for (genvar g = 0; g < W; g++) begin : g_chan
    key_event_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_sw      (key_sw[g]),
      .key_pressed (key_pressed[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g])
    );
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomised + directed bench for key_event_decoder with a cycle scoreboard.
module tb_key_event_decoder;

  localparam int W  = 4;
  localparam int S  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] key_sw = '1;
  logic [W-1:0] key_pressed, key_press, key_release;

  key_event_decoder #(
    .W(W), .STABLE_CYCLES(S), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_sw(key_sw),
    .key_pressed(key_pressed), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lvl;
    logic [W-1:0] prs;
    logic [W-1:0] rel;
  } exp_t;

  typedef struct {
    int e;
    int b;
    bit rel;
  } ev_t;

  exp_t exp_q[$];
  ev_t  ev_log[$];
  int   errors = 0;
  int   checks = 0;
  int   e = 0;

  // Reference: a new level is accepted once S consecutive synchronised
  // samples (raw samples delayed two edges) differ from the accepted level.
  bit m_l[W];
  int m_run[W];
  bit h1[W], h2[W];
`ifdef KEY_AUTOREPEAT_EN
  int m_held[W];
`endif

  always @(posedge clk) begin
    exp_t x;
    bit   s;
`ifdef KEY_AUTOREPEAT_EN
    bit   held;
`endif
    x.lvl = '0; x.prs = '0; x.rel = '0;
    e++;
    if (!reset_n) begin
      for (int i = 0; i < W; i++) begin
        m_l[i] = 0; m_run[i] = 0; h1[i] = 0; h2[i] = 0;
`ifdef KEY_AUTOREPEAT_EN
        m_held[i] = 0;
`endif
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        s = h2[i];
`ifdef KEY_AUTOREPEAT_EN
        held = m_l[i] && (m_run[i] == 0);
`endif
        h2[i] = h1[i];
        h1[i] = ~key_sw[i];
        if (s != m_l[i]) begin
          m_run[i]++;
          if (m_run[i] == S) begin
            m_l[i] = s;
            m_run[i] = 0;
            if (s) x.prs[i] = 1'b1; else x.rel[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            m_held[i] = 0;
`endif
          end
        end else begin
          m_run[i] = 0;
`ifdef KEY_AUTOREPEAT_EN
          if (held) begin
            m_held[i]++;
            if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RP == 0))
              x.prs[i] = 1'b1;
          end
`endif
        end
        x.lvl[i] = m_l[i];
      end
    end
    exp_q.push_back(x);
  end

  // Monitor: every cycle the DUT presents its outputs; compare with the model.
  always @(posedge clk) begin
    exp_t x;
    ev_t  ev;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow at edge %0d", e);
    end else begin
      x = exp_q.pop_front();
      if (key_pressed !== x.lvl || key_press !== x.prs || key_release !== x.rel) begin
        errors++;
        $display("FAIL cycle_compare edge %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=%b",
                 e, key_pressed, key_press, key_release, x.lvl, x.prs, x.rel);
      end
    end
    for (int b = 0; b < W; b++) begin
      if (key_press[b] === 1'b1) begin
        ev.e = e; ev.b = b; ev.rel = 1'b0; ev_log.push_back(ev);
      end
      if (key_release[b] === 1'b1) begin
        ev.e = e; ev.b = b; ev.rel = 1'b1; ev_log.push_back(ev);
      end
    end
  end

  function automatic int nth_ev(int b, bit rel, int from, int to, int n);
    int k = 0;
    foreach (ev_log[i]) begin
      if (ev_log[i].b == b && ev_log[i].rel == rel && ev_log[i].e >= from && ev_log[i].e <= to) begin
        if (k == n) return ev_log[i].e;
        k++;
      end
    end
    return -1;
  endfunction

  function automatic int count_ev(int b, bit rel, int from, int to);
    int k = 0;
    foreach (ev_log[i])
      if (ev_log[i].b == b && ev_log[i].rel == rel && ev_log[i].e >= from && ev_log[i].e <= to)
        k++;
    return k;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k, t0, a, n_exp, rst_left, exp_e;

    reset_n = 1'b0;
    key_sw  = '1;
    tick(3);
    check_int("reset_outputs", int'({key_pressed, key_press, key_release}), 0);
    reset_n = 1'b1;
    tick(5);

    // 1: single press latency, other bits quiet
    t0 = e + 1;
    key_sw[0] = 1'b0; k = e + 1;
    tick(10);
    check_int("t1_press_edge", nth_ev(0, 0, t0, e, 0), k + 1 + S);
    check_int("t1_pressed_lvl", int'(key_pressed[0]), 1);
    for (int b = 1; b < W; b++) check_int("t1_other_bits", count_ev(b, 0, t0, e), 0);

    // 2: short glitch is dropped
    t0 = e + 1;
    key_sw[1] = 1'b0; tick(2); key_sw[1] = 1'b1;
    tick(10);
    check_int("t2_no_press", count_ev(1, 0, t0, e), 0);
    check_int("t2_level", int'(key_pressed[1]), 0);

    // 3: bouncy release yields exactly one release pulse
    t0 = e + 1;
    key_sw[0] = 1'b1; tick(1); key_sw[0] = 1'b0; tick(2);
    key_sw[0] = 1'b1; tick(1); key_sw[0] = 1'b0; tick(1);
    key_sw[0] = 1'b1; k = e + 1;
    tick(10);
    check_int("t3_release_count", count_ev(0, 1, t0, e), 1);
    check_int("t3_release_edge", nth_ev(0, 1, t0, e, 0), k + 1 + S);
    check_int("t3_level", int'(key_pressed[0]), 0);

    // 4: reset mid-debounce, key held through reset
    t0 = e + 1;
    key_sw[2] = 1'b0; tick(3);
    reset_n = 1'b0; tick(3);
    check_int("t4_outputs_in_reset", int'({key_pressed, key_press, key_release}), 0);
    reset_n = 1'b1; k = e + 1;
    tick(10);
    check_int("t4_press_count", count_ev(2, 0, t0, e), 1);
    check_int("t4_press_edge", nth_ev(2, 0, t0, e, 0), k + 1 + S);
    key_sw[2] = 1'b1; tick(10);

    // 5: all keys together
    key_sw = '0; k = e + 1;
    tick(8);
    for (int b = 0; b < W; b++) begin
      check_int("t5_press_edge", nth_ev(b, 0, k, e, 0), k + 1 + S);
      check_int("t5_press_count", count_ev(b, 0, k, e), 1);
    end
    key_sw = '1; tick(10);

    // 6: long hold, repeat pulses only with auto-repeat built in
    key_sw[3] = 1'b0; k = e + 1; a = k + 1 + S;
    tick(a + 30 - e + 1);
`ifdef KEY_AUTOREPEAT_EN
    n_exp = 1 + ((30 - RD) / RP) + 1;
`else
    n_exp = 1;
`endif
    check_int("t6_press_count", count_ev(3, 0, k, a + 30), n_exp);
    for (int j = 0; j < n_exp; j++) begin
      exp_e = (j == 0) ? a : a + RD + (j - 1) * RP;
      check_int("t6_press_edge", nth_ev(3, 0, k, a + 30, j), exp_e);
    end
    key_sw[3] = 1'b1; tick(10);

    // Random phase: independent key toggling with occasional resets
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!reset_n) begin
        if (rst_left > 0) rst_left--; else reset_n = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        rst_left = 2;
      end
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 7) == 0) key_sw[b] = ~key_sw[b];
    end
    reset_n = 1'b1;
    tick(3);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
